sim_data_demux: RTL
===================

# sim_data_demux

Data-side bus splitter for the HWPE simulation top. It sits between the RISC-V core data port and three slave ports: the HWPE peripheral port, the stack memory and the shared TCDM. It also contains a local exit/status register. Requests are decoded and routed in the same cycle. Each granted request records its target in an in-order tracking FIFO, so every response is returned from the correct slave and no ambiguous OR-ing of responses can occur. The status register replaces ad-hoc end-of-test snooping.

## Interface
Parameters:
- HWPE_ADDR_BASE_BIT, 20: address bit that selects the HWPE peripheral port.
- MAX_OUTSTANDING, 2: tracking FIFO depth. Must be at least 1.
- EXIT_ADDR, 32'h8000_0000: word address of the exit/status register.

Ports:
- clk_i, in, 1: clock. One clock domain only.
- rst_ni, in, 1: asynchronous active-low reset.
- data_req_i, data_we_i, data_be_i[3:0], data_addr_i[31:0], data_wdata_i[31:0], in: core request.
- data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o[31:0], out: core response. data_err_o is always 0.
- periph_req_o, periph_wen_o, periph_be_o[3:0], periph_add_o[31:0], periph_data_o[31:0], out: peripheral request. wen is active-low.
- periph_gnt_i, periph_r_valid_i, periph_r_data_i[31:0], in: peripheral response.
- stack_*: same port set as periph_*.
- tcdm_*: same port set as periph_*. tcdm_add_o = {8'b0, data_addr_i[23:0]}.
- exit_valid_o, out, 1: sticky. Set by the first write to EXIT_ADDR.
- exit_code_o, out, 32: exit/status register contents.
- proto_err_o, out, 1: sticky flag for an unexpected slave response.

## Operation
- Decode priority, evaluated on data_addr_i:
  - addr == EXIT_ADDR → EXIT (local register).
  - addr[HWPE_ADDR_BASE_BIT] set → PERIPH.
  - addr[31:24] == 0 → STACK.
  - otherwise → TCDM.
- Slave request signals:
  - Only the decoded slave's req_o can be 1.
  - That req_o = data_req_i & ~full.
  - add, be and data pass through unchanged, with the TCDM add exception above. wen_o = ~data_we_i.
- data_gnt_o:
  - Equals the decoded slave's gnt_i, or 1 for EXIT.
  - Forced to 0 while the FIFO is full.
- Tracking FIFO:
  - Entries are 2-bit target codes: PERIPH=0, STACK=1, TCDM=2, EXIT=3.
  - Push on data_req_i & data_gnt_o. Pop when the head's response is delivered.
- Response routing:
  - data_rvalid_o and data_rdata_o are taken only from the slave named by the FIFO head.
  - A slave r_valid_i in either of these cases sets proto_err_o and is dropped:
    - it comes from a slave other than the head;
    - it arrives while the FIFO is empty.
- EXIT accesses:
  - Write: bytes of exit_code_o are updated per data_be_i, and exit_valid_o is set.
  - Read: returns exit_code_o.
  - The response is given in the first cycle in which the EXIT entry is at the head and has been in the FIFO for at least one cycle.
- Simultaneous push and pop are allowed and leave the count unchanged. Full is evaluated on the registered count, with no same-cycle bypass.

## Timing
- Request to slave req: 0 cycles (combinational). Slave gnt to data_gnt_o: 0 cycles.
- Slave responses pass through combinationally in the cycle r_valid_i is high.
- EXIT: grant in cycle N, data_rvalid_o in cycle N+1 at the earliest, and later if older responses are still pending.
- Reset: FIFO empty (count=0), exit_valid_o=0, exit_code_o=0, proto_err_o=0, data_rvalid_o=0.
- Reset mid-transaction: all tracking state is cleared. Late slave responses arriving after reset raise proto_err_o. The bench must not do this except in the dedicated test.
- A single slave is never required to respond in fewer than 1 cycle after grant.

## Configuration
- SIM_DATA_DEMUX_ASSERT_EN defined:
  - Simulation checks are compiled in.
  - $error when proto_err_o rises.
  - $error if data_req_i drops, or the address changes, before grant.
  - $display("errors=%08x", exit_code_o) on the first exit write.
- Macro undefined: no checks or prints. All functional behaviour, including proto_err_o, is identical.

## Test plan
- Write 0x0000_0010 to 0x0000_1000, then read it back → stack_req_o=1, stack_wen_o=0 on the write; the read returns 0x10 through the stack path; periph_req_o and tcdm_req_o stay 0.
- Read 0x1010_0000 with HWPE_ADDR_BASE_BIT=20 → periph_req_o=1 (periph wins over TCDM); the response rdata is taken only from periph_r_data_i while tcdm_r_data_i=0xDEAD_BEEF.
- Back-to-back TCDM read, then EXIT read, with the TCDM response delayed 3 cycles → the EXIT response is held until after the TCDM response, and responses arrive in order.
- Three consecutive grants with MAX_OUTSTANDING=2 and no responses → the third request sees data_gnt_o=0 and tcdm_req_o=0 until one response pops.
- Write 0x0000_0000 with be=4'hF to 0x8000_0000 → exit_valid_o=1 and exit_code_o=0 on the next cycle, and both hold through later traffic; a second write with be=4'b0001 and data 0x05 gives exit_code_o=0x05.
- Pulse stack_r_valid_i with the FIFO empty → proto_err_o=1 and stays 1; data_rvalid_o stays 0.

Source files
------------

// File: rtl/sim_data_demux.sv
// Data-side bus splitter: core data port -> HWPE periph / stack / TCDM, plus a local exit/status register.
// Latency: request, grant and slave responses are combinational; EXIT accesses respond >=1 cycle after grant.
// Backpressure: data_gnt_o follows the target's gnt_i and is forced low while the tracking FIFO is full.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   data_*                             core request / response
//   periph_*, stack_*, tcdm_*          slave request (wen active-low) / response ports
//   exit_valid_o, exit_code_o          sticky exit flag and exit/status register contents
//   proto_err_o                        sticky flag for a response arriving from a non-head slave
// Optional build macro: SIM_DATA_DEMUX_ASSERT_EN compiles in simulation-only protocol checks and
// the exit print. Functional behaviour is identical with or without it.

module sim_data_demux #(
  parameter int          HWPE_ADDR_BASE_BIT = 20,
  parameter int          MAX_OUTSTANDING    = 2,
  parameter logic [31:0] EXIT_ADDR          = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,

  output logic        periph_req_o,
  output logic        periph_wen_o,
  output logic [3:0]  periph_be_o,
  output logic [31:0] periph_add_o,
  output logic [31:0] periph_data_o,
  input  logic        periph_gnt_i,
  input  logic        periph_r_valid_i,
  input  logic [31:0] periph_r_data_i,

  output logic        stack_req_o,
  output logic        stack_wen_o,
  output logic [3:0]  stack_be_o,
  output logic [31:0] stack_add_o,
  output logic [31:0] stack_data_o,
  input  logic        stack_gnt_i,
  input  logic        stack_r_valid_i,
  input  logic [31:0] stack_r_data_i,

  output logic        tcdm_req_o,
  output logic        tcdm_wen_o,
  output logic [3:0]  tcdm_be_o,
  output logic [31:0] tcdm_add_o,
  output logic [31:0] tcdm_data_o,
  input  logic        tcdm_gnt_i,
  input  logic        tcdm_r_valid_i,
  input  logic [31:0] tcdm_r_data_i,

  output logic        exit_valid_o,
  output logic [31:0] exit_code_o,
  output logic        proto_err_o
);

  localparam logic [1:0] TGT_PERIPH = 2'd0;
  localparam logic [1:0] TGT_STACK  = 2'd1;
  localparam logic [1:0] TGT_TCDM   = 2'd2;
  localparam logic [1:0] TGT_EXIT   = 2'd3;

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [1:0]       tgt;
  logic             tgt_gnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       head;
  logic             rsp_vld;
  logic [31:0]      rsp_dat;
  logic             stray;
  logic             exit_wr;
  logic [31:0]      exit_code_nxt;

  logic [1:0]       fifo_q [0:MAX_OUTSTANDING-1];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             exit_valid_q;
  logic [31:0]      exit_code_q;
  logic             proto_err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  // Address decode, highest priority first.
  always_comb begin
    if (data_addr_i == EXIT_ADDR)          tgt = TGT_EXIT;
    else if (data_addr_i[HWPE_ADDR_BASE_BIT]) tgt = TGT_PERIPH;
    else if (data_addr_i[31:24] == 8'h00)  tgt = TGT_STACK;
    else                                   tgt = TGT_TCDM;
  end

  always_comb begin
    tgt_gnt = 1'b1;
    case (tgt)
      TGT_PERIPH: tgt_gnt = periph_gnt_i;
      TGT_STACK:  tgt_gnt = stack_gnt_i;
      TGT_TCDM:   tgt_gnt = tcdm_gnt_i;
      default:    tgt_gnt = 1'b1;
    endcase
  end

  // Full uses the registered count only: a same-cycle pop does not free a slot.
  assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty      = (count_q == '0);
  assign data_gnt_o = tgt_gnt & ~full;
  assign push       = data_req_i & data_gnt_o;

  assign periph_req_o  = data_req_i & ~full & (tgt == TGT_PERIPH);
  assign periph_wen_o  = ~data_we_i;
  assign periph_be_o   = data_be_i;
  assign periph_add_o  = data_addr_i;
  assign periph_data_o = data_wdata_i;

  assign stack_req_o   = data_req_i & ~full & (tgt == TGT_STACK);
  assign stack_wen_o   = ~data_we_i;
  assign stack_be_o    = data_be_i;
  assign stack_add_o   = data_addr_i;
  assign stack_data_o  = data_wdata_i;

  assign tcdm_req_o    = data_req_i & ~full & (tgt == TGT_TCDM);
  assign tcdm_wen_o    = ~data_we_i;
  assign tcdm_be_o     = data_be_i;
  assign tcdm_add_o    = {8'b0, data_addr_i[23:0]};
  assign tcdm_data_o   = data_wdata_i;

  assign head = fifo_q[rd_ptr_q];

  // Only the head's slave may answer; anything else is a protocol error and is dropped.
  // An EXIT entry in the FIFO was pushed on an earlier edge, so it may answer as soon as it is head.
  always_comb begin
    rsp_vld = 1'b0;
    rsp_dat = '0;
    stray   = periph_r_valid_i | stack_r_valid_i | tcdm_r_valid_i;
    if (!empty) begin
      case (head)
        TGT_PERIPH: begin
          rsp_vld = periph_r_valid_i;
          rsp_dat = periph_r_data_i;
          stray   = stack_r_valid_i | tcdm_r_valid_i;
        end
        TGT_STACK: begin
          rsp_vld = stack_r_valid_i;
          rsp_dat = stack_r_data_i;
          stray   = periph_r_valid_i | tcdm_r_valid_i;
        end
        TGT_TCDM: begin
          rsp_vld = tcdm_r_valid_i;
          rsp_dat = tcdm_r_data_i;
          stray   = periph_r_valid_i | stack_r_valid_i;
        end
        default: begin
          rsp_vld = 1'b1;
          rsp_dat = exit_code_q;
        end
      endcase
    end
  end

  assign pop           = rsp_vld;
  assign data_rvalid_o = rsp_vld;
  assign data_rdata_o  = rsp_dat;
  assign data_err_o    = 1'b0;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= tgt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Exit register is written at grant time so a read right behind it sees the new value.
  assign exit_wr = push & (tgt == TGT_EXIT) & data_we_i;

  always_comb begin
    exit_code_nxt = exit_code_q;
    for (int b = 0; b < 4; b++) begin
      if (data_be_i[b]) exit_code_nxt[8*b +: 8] = data_wdata_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      if (exit_wr) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= exit_code_nxt;
      end
      if (stray) proto_err_q <= 1'b1;
    end
  end

  assign exit_valid_o = exit_valid_q;
  assign exit_code_o  = exit_code_q;
  assign proto_err_o  = proto_err_q;

`ifdef SIM_DATA_DEMUX_ASSERT_EN
  logic        chk_pend_q;
  logic [31:0] chk_addr_q;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_pend_q <= 1'b0;
      chk_addr_q <= '0;
    end else begin
      if (chk_pend_q && !data_req_i)
        $error("sim_data_demux: data_req_i dropped before grant");
      if (chk_pend_q && data_req_i && (data_addr_i != chk_addr_q))
        $error("sim_data_demux: data_addr_i changed before grant");
      if (stray && !proto_err_q)
        $error("sim_data_demux: unexpected slave response");
      if (exit_wr && !exit_valid_q)
        $display("errors=%08x", exit_code_nxt);
      chk_pend_q <= data_req_i & ~data_gnt_o;
      chk_addr_q <= data_addr_i;
    end
  end
`else
  // Simulation checks not compiled in this build.
`endif

endmodule
